// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar register bus: address map, bus width,
// initiator state encoding and a select-width helper.
package sonar_pkg;

  localparam int BUS_WIDTH = 16;

  localparam logic [3:0] ADR_CONTROL   = 4'd0;
  localparam logic [3:0] ADR_STATUS    = 4'd1;
  localparam logic [3:0] ADR_FREQ      = 4'd2;
  localparam logic [3:0] ADR_PULSES    = 4'd3;
  localparam logic [3:0] ADR_TIMER     = 4'd4;
  localparam logic [3:0] ADR_GAIN      = 4'd5;
  localparam logic [3:0] ADR_AMP       = 4'd6;
  localparam logic [3:0] ADR_THRESHOLD = 4'd7;
  localparam logic [3:0] ADR_ECHO_CNT  = 4'd8;
  localparam logic [3:0] ADR_TOF       = 4'd9;
  localparam logic [3:0] ADR_DEBUG     = 4'd10;
  localparam logic [3:0] ADR_FB0       = 4'd11;
  localparam logic [3:0] ADR_FB1       = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    RETRY = 2'd3
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_wbm_timeout.sv
// Loadable down-counter used as a bus-cycle watchdog; o_expired is high
// whenever the count has reached zero.
module sonar_wbm_timeout #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Count register: clear beats load beats decrement, saturating at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/sonar_wb_master.sv
// Command-to-bus initiator for an array of sonar register slaves.
// Optional macro SONAR_WBM_RETRY_EN: reissue a timed-out cycle once before erroring.
module sonar_wb_master
  import sonar_pkg::*;
#(
  parameter int INSTANCE_NUM   = 4,
  parameter int SEL_W          = sel_width(INSTANCE_NUM),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [SEL_W-1:0]        cmd_sel_i,
  input  logic [3:0]              cmd_adr_i,
  input  logic [BUS_WIDTH-1:0]    cmd_dat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [BUS_WIDTH-1:0]    rsp_dat_o,
  output logic                    rsp_err_o,
  output logic [INSTANCE_NUM-1:0] wb_valid_o,
  output logic [3:0]              wbs_adr_o,
  output logic [BUS_WIDTH-1:0]    wbs_dat_o,
  output logic                    wbs_strb_o,
  input  logic                    wbs_ack_i,
  input  logic [BUS_WIDTH-1:0]    wbs_dat_i
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [BUS_WIDTH-1:0]    r_rsp_dat;
  logic [INSTANCE_NUM-1:0] r_valid;
  logic [3:0]              r_adr;
  logic [BUS_WIDTH-1:0]    r_wdat;
  logic                    r_strb;
  logic                    r_we;
`ifdef SONAR_WBM_RETRY_EN
  logic                    r_retry;
  logic [INSTANCE_NUM-1:0] r_onehot;
`endif

  logic                    w_accept;
  logic                    w_sel_bad;
  logic [INSTANCE_NUM-1:0] w_onehot;
  logic                    w_tmr_load;
  logic                    w_tmr_en;
  logic                    w_tmr_clr;
  logic                    w_expired;

  assign w_accept  = (r_state == IDLE) && cmd_valid_i && r_cmd_ready;
  assign w_sel_bad = (32'(cmd_sel_i) >= 32'(INSTANCE_NUM));

  // One-hot decode of the requested instance.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < INSTANCE_NUM; i++) begin
      w_onehot[i] = (32'(cmd_sel_i) == 32'(i));
    end
  end

  // The watchdog restarts each time a bus cycle is (re)issued.
  assign w_tmr_load = (w_accept && !w_sel_bad) || (r_state == RETRY);
  assign w_tmr_en   = (r_state == BUS) && !wbs_ack_i;
  assign w_tmr_clr  = (r_state == RESP);

  sonar_wbm_timeout #(.W(TO_W)) u_timeout (
    .i_clk      (wb_clk_i),
    .i_rst_n    (wb_rst_i),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (TO_LOAD),
    .i_en       (w_tmr_en),
    .o_expired  (w_expired)
  );

  // Transaction sequencer with registered bus and host outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
      r_valid     <= '0;
      r_adr       <= 4'd0;
      r_wdat      <= '0;
      r_strb      <= 1'b0;
      r_we        <= 1'b0;
`ifdef SONAR_WBM_RETRY_EN
      r_retry     <= 1'b0;
      r_onehot    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_we        <= cmd_we_i;
`ifdef SONAR_WBM_RETRY_EN
            r_retry     <= 1'b0;
            r_onehot    <= w_onehot;
`endif
            if (w_sel_bad) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_dat   <= '0;
              r_state     <= RESP;
            end else begin
              r_valid <= w_onehot;
              r_adr   <= cmd_adr_i;
              r_wdat  <= cmd_dat_i;
              r_strb  <= cmd_we_i;
              r_state <= BUS;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          if (wbs_ack_i) begin
            r_valid     <= '0;
            r_strb      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= r_we ? 16'h0000 : wbs_dat_i;
            r_state     <= RESP;
          end else if (w_expired) begin
            r_valid <= '0;
            r_strb  <= 1'b0;
`ifdef SONAR_WBM_RETRY_EN
            if (!r_retry) begin
              r_retry <= 1'b1;
              r_state <= RETRY;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_dat   <= '0;
              r_state     <= RESP;
            end
`else
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= '0;
            r_state     <= RESP;
`endif
          end else begin
            r_state <= BUS;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
`ifdef SONAR_WBM_RETRY_EN
        RETRY: begin
          r_valid <= r_onehot;
          r_strb  <= r_we;
          r_state <= BUS;
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;
  assign wb_valid_o  = r_valid;
  assign wbs_adr_o   = r_adr;
  assign wbs_dat_o   = r_wdat;
  assign wbs_strb_o  = r_strb;

endmodule
